// File: rtl/wb_unit_pkg.sv
// Shared CPU definitions for the write-back stage: load-width encodings,
// the return-address register index and the MEM/WB pipeline register layout.
package wb_unit_pkg;

  typedef enum logic [1:0] {
    LB_WORD  = 2'b00,
    LB_SBYTE = 2'b01,
    LB_UBYTE = 2'b10,
    LB_SHALF = 2'b11
  } load_byte_e;

  localparam int unsigned RA_IDX = 31;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [31:0] pc_addr;
    logic [4:0]  rw;
    logic        reg_wr;
    logic        mem_to_reg;
    logic        overflow;
    logic        jal;
    logic [1:0]  load_byte;
  } mem_wb_t;

endpackage

// File: rtl/wb_unit_load_align.sv
// Little-endian load alignment: picks the addressed byte/halfword out of a
// memory word and zero- or sign-extends it to 32 bits.
module load_align
  import wb_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  load_byte,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{addr, 3'b000} +: 8];
  // Halfword loads ignore addr[0]; misaligned halves fold to the aligned one.
  assign half_sel = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    // NOTE: value gets a default before the case so no path leaves it unassigned (no latch).
    value = word;
    case (load_byte_e'(load_byte))
      LB_WORD:  value = word;
      LB_SBYTE: value = {{24{byte_sel[7]}}, byte_sel};
      LB_UBYTE: value = {24'h0, byte_sel};
      LB_SHALF: value = {{16{half_sel[15]}}, half_sel};
      default:  value = word;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// MEM/WB pipeline register plus write-back mux: produces register-file write
// data/address/enable and counts retired instructions.
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned RA_REG = RA_IDX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_Mem,
  input  logic [31:0]      ALUResult_Mem,
  input  logic [31:0]      MemData_Mem,
  input  logic [31:0]      PC_Addr_Mem,
  input  logic [4:0]       Rw_Mem,
  input  logic             RegWr_Mem,
  input  logic             MemToReg_Mem,
  input  logic             OverFlow_Mem,
  input  logic             Jal_Mem,
  input  logic [1:0]       LoadByte_Mem,
  output logic [31:0]      busW,
  output logic [4:0]       Rw_Wr,
  output logic             RegWr_Wr,
  output logic             OverFlow_Wr,
  output logic             Jal_Wr,
  output logic             valid_Wr,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [4:0] RA_ADDR = 5'(RA_REG);

  mem_wb_t mem_d;
  mem_wb_t wb_q;
  logic [31:0] load_value;

  assign mem_d = '{
    valid:      valid_Mem,
    alu_result: ALUResult_Mem,
    mem_data:   MemData_Mem,
    pc_addr:    PC_Addr_Mem,
    rw:         Rw_Mem,
    reg_wr:     RegWr_Mem,
    mem_to_reg: MemToReg_Mem,
    overflow:   OverFlow_Mem,
    jal:        Jal_Mem,
    load_byte:  LoadByte_Mem
  };

  // Reset beats flush, flush beats stall: a flushed slot becomes an all-zero bubble.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n)      wb_q <= '0;
    else if (flush)  wb_q <= '0;
    else if (!stall) wb_q <= mem_d;
  end

  // Counts the instruction leaving WB; overflowed instructions still retire.
  always_ff @(posedge clk) begin
    if (!rst_n)                   retire_cnt <= '0;
    else if (wb_q.valid && !stall) retire_cnt <= retire_cnt + CNT_W'(1);
  end

  load_align u_load_align (
    .word      (wb_q.mem_data),
    .addr      (wb_q.alu_result[1:0]),
    .load_byte (wb_q.load_byte),
    .value     (load_value)
  );

  always_comb begin
    busW = wb_q.alu_result;
    if (wb_q.jal)             busW = wb_q.pc_addr + 32'd4;
    else if (wb_q.mem_to_reg) busW = load_value;
  end

  assign Rw_Wr       = wb_q.jal ? RA_ADDR : wb_q.rw;
  assign RegWr_Wr    = wb_q.valid & wb_q.reg_wr & (Rw_Wr != 5'd0);
  assign OverFlow_Wr = wb_q.overflow;
  assign Jal_Wr      = wb_q.jal;
  assign valid_Wr    = wb_q.valid;

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed scenarios plus randomized traffic
// compared against a behavioural model of the write-back stage.
module tb_wb_unit;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n, stall, flush, valid_Mem;
  logic [31:0]   ALUResult_Mem, MemData_Mem, PC_Addr_Mem;
  logic [4:0]    Rw_Mem;
  logic          RegWr_Mem, MemToReg_Mem, OverFlow_Mem, Jal_Mem;
  logic [1:0]    LoadByte_Mem;
  logic [31:0]   busW;
  logic [4:0]    Rw_Wr;
  logic          RegWr_Wr, OverFlow_Wr, Jal_Wr, valid_Wr;
  logic [CW-1:0] retire_cnt;

  int n_checks = 0;
  int n_errors = 0;

  wb_unit #(.CNT_W(CW), .RA_REG(31)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .valid_Mem(valid_Mem), .ALUResult_Mem(ALUResult_Mem),
    .MemData_Mem(MemData_Mem), .PC_Addr_Mem(PC_Addr_Mem), .Rw_Mem(Rw_Mem),
    .RegWr_Mem(RegWr_Mem), .MemToReg_Mem(MemToReg_Mem),
    .OverFlow_Mem(OverFlow_Mem), .Jal_Mem(Jal_Mem), .LoadByte_Mem(LoadByte_Mem),
    .busW(busW), .Rw_Wr(Rw_Wr), .RegWr_Wr(RegWr_Wr), .OverFlow_Wr(OverFlow_Wr),
    .Jal_Wr(Jal_Wr), .valid_Wr(valid_Wr), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // Model of the instruction currently in WB, as the ISA sees it.
  typedef struct {
    bit          valid, reg_wr, mem_to_reg, ovf, jal;
    logic [31:0] alu, mdata, pc;
    logic [4:0]  rw;
    logic [1:0]  lb;
  } instr_t;

  instr_t        m_wb;
  logic [CW-1:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] lb);
    logic [31:0] s;
    case (lb)
      2'd0: return w;
      2'd1: begin s = w >> (8 * a); return 32'($signed(s[7:0])); end
      2'd2: begin s = w >> (8 * a); return {24'h0, s[7:0]}; end
      default: begin s = w >> (16 * a[1]); return 32'($signed(s[15:0])); end
    endcase
  endfunction

  function automatic logic [31:0] ref_busw(input instr_t i);
    if (i.jal) return i.pc + 32'd4;
    if (i.mem_to_reg) return ref_load(i.mdata, i.alu[1:0], i.lb);
    return i.alu;
  endfunction

  function automatic logic [4:0] ref_rw(input instr_t i);
    return i.jal ? 5'd31 : i.rw;
  endfunction

  task automatic compare_all();
    check("busW", busW, ref_busw(m_wb));
    check("Rw_Wr", 32'(Rw_Wr), 32'(ref_rw(m_wb)));
    check("RegWr_Wr", 32'(RegWr_Wr),
          32'(m_wb.valid && m_wb.reg_wr && ref_rw(m_wb) != 5'd0));
    check("OverFlow_Wr", 32'(OverFlow_Wr), 32'(m_wb.ovf));
    check("Jal_Wr", 32'(Jal_Wr), 32'(m_wb.jal));
    check("valid_Wr", 32'(valid_Wr), 32'(m_wb.valid));
    check("retire_cnt", 32'(retire_cnt), 32'(m_cnt));
  endtask

  // One clock: advance the model with the inputs presented, then compare.
  task automatic cycle();
    instr_t in;
    in = '{valid: valid_Mem, reg_wr: RegWr_Mem, mem_to_reg: MemToReg_Mem,
           ovf: OverFlow_Mem, jal: Jal_Mem, alu: ALUResult_Mem, mdata: MemData_Mem,
           pc: PC_Addr_Mem, rw: Rw_Mem, lb: LoadByte_Mem};
    @(posedge clk);
    if (!rst_n) begin
      m_wb  = '{default: '0};
      m_cnt = '0;
    end else begin
      if (m_wb.valid && !stall) m_cnt = m_cnt + 1'b1;
      if (flush) m_wb = '{default: '0};
      else if (!stall) m_wb = in;
    end
    #1;
    compare_all();
  endtask

  task automatic drive(input bit v, input logic [31:0] alu, input logic [31:0] md,
                       input logic [31:0] pc, input logic [4:0] rw, input bit rwr,
                       input bit mtr, input bit ovf, input bit jal, input logic [1:0] lb);
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    valid_Mem = v; ALUResult_Mem = alu; MemData_Mem = md; PC_Addr_Mem = pc;
    Rw_Mem = rw; RegWr_Mem = rwr; MemToReg_Mem = mtr; OverFlow_Mem = ovf;
    Jal_Mem = jal; LoadByte_Mem = lb;
  endtask

  task automatic drive_random();
    drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
          5'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, 2'($urandom));
    stall = $urandom_range(0, 4) == 0;
    flush = $urandom_range(0, 9) == 0;
    rst_n = $urandom_range(0, 49) != 0;
  endtask

  task automatic load_case(input logic [1:0] lb, input logic [1:0] a, input logic [31:0] exp,
                           input string tag);
    drive(1, {28'h1000000, 2'b00, a}, 32'h80FF7F01, 32'h0, 5'd9, 1, 1, 0, 0, lb);
    cycle();
    check(tag, busW, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0]   held_busw;
    logic [CW-1:0] held_cnt;
    m_wb = '{default: '0};
    m_cnt = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    cycle();
    cycle();
    check("rst_busW", busW, 32'h0);
    check("rst_valid", 32'(valid_Wr), 32'h0);
    check("rst_cnt", 32'(retire_cnt), 32'h0);

    // ALU result write-back.
    drive(1, 32'h12345678, 0, 32'h100, 5'd8, 1, 0, 0, 0, 0);
    cycle();
    check("alu_busW", busW, 32'h12345678);
    check("alu_Rw", 32'(Rw_Wr), 32'd8);
    check("alu_RegWr", 32'(RegWr_Wr), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    check("alu_cnt", 32'(retire_cnt), 32'd1);

    load_case(2'b01, 2'b01, 32'h0000007F, "ld_sbyte1");
    load_case(2'b01, 2'b11, 32'hFFFFFF80, "ld_sbyte3");
    load_case(2'b10, 2'b11, 32'h00000080, "ld_ubyte3");
    load_case(2'b11, 2'b10, 32'hFFFF80FF, "ld_shalf2");
    load_case(2'b11, 2'b11, 32'hFFFF80FF, "ld_shalf3");
    load_case(2'b00, 2'b10, 32'h80FF7F01, "ld_word");

    // Jal to $ra.
    drive(1, 32'hDEAD0000, 0, 32'h00400010, 5'd0, 1, 0, 0, 1, 0);
    cycle();
    check("jal_busW", busW, 32'h00400014);
    check("jal_Rw", 32'(Rw_Wr), 32'd31);
    check("jal_RegWr", 32'(RegWr_Wr), 32'd1);
    check("jal_Jal", 32'(Jal_Wr), 32'd1);

    // Stall 3 cycles, then flush while stalled.
    drive(1, 32'hCAFE0001, 0, 0, 5'd3, 1, 0, 0, 0, 0);
    cycle();
    held_busw = busW;
    held_cnt  = retire_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, $urandom, $urandom, 5'd7, 1, 0, 0, 0, 0);
      stall = 1'b1;
      cycle();
      check("stall_busW", busW, 32'hCAFE0001);
      check("stall_cnt", 32'(retire_cnt), 32'(held_cnt));
    end
    stall = 1'b1;
    flush = 1'b1;
    cycle();
    check("flush_valid", 32'(valid_Wr), 32'd0);
    check("flush_RegWr", 32'(RegWr_Wr), 32'd0);
    check("flush_cnt", 32'(retire_cnt), 32'(held_cnt));

    // $zero destination and overflow.
    drive(1, 32'h55, 0, 0, 5'd0, 1, 0, 0, 0, 0);
    cycle();
    check("zero_RegWr", 32'(RegWr_Wr), 32'd0);
    held_cnt = retire_cnt;
    drive(1, 32'h66, 0, 0, 5'd4, 1, 0, 1, 0, 0);
    cycle();
    check("ovf_flag", 32'(OverFlow_Wr), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    check("ovf_cnt", 32'(retire_cnt), 32'(held_cnt + 2'd2));

    // Counter wrap from all-ones.
    rst_n = 1'b0;
    cycle();
    for (int i = 0; i < 600 && m_cnt != '1; i++) begin
      drive(1, i, 0, 0, 5'd1, 1, 0, 0, 0, 0);
      cycle();
    end
    check("cnt_allones", 32'(retire_cnt), 32'h000000FF);
    cycle();
    check("cnt_wrap", 32'(retire_cnt), 32'h0);

    // Reset while stalled discards the in-flight instruction.
    drive(1, 32'h77, 0, 0, 5'd5, 1, 0, 1, 1, 0);
    cycle();
    stall = 1'b1;
    rst_n = 1'b0;
    cycle();
    check("rst_stall_busW", busW, 32'h0);
    check("rst_stall_Rw", 32'(Rw_Wr), 32'h0);
    check("rst_stall_flags", {28'h0, RegWr_Wr, OverFlow_Wr, Jal_Wr, valid_Wr}, 32'h0);
    check("rst_stall_cnt", 32'(retire_cnt), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      drive_random();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retire counter.
REQ-002 SHALL have parameter RA_REG, default 31: destination register index for Jal writes.
REQ-003 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-005 SHALL have port stall  input  1: hold MEM/WB register contents.
REQ-006 SHALL have port flush  input  1: load a bubble instead of MEM-stage data.
REQ-007 SHALL have port valid_Mem  input  1: MEM stage holds a real instruction.
REQ-008 SHALL have port ALUResult_Mem  input  32: ALU result / memory address.
REQ-009 SHALL have port MemData_Mem  input  32: raw word read from data memory.
REQ-010 SHALL have port PC_Addr_Mem  input  32: PC of the instruction.
REQ-011 SHALL have port Rw_Mem  input  5: destination register.
REQ-012 SHALL have ports RegWr_Mem, MemToReg_Mem, OverFlow_Mem, Jal_Mem  input  1 each: control bits.
REQ-013 SHALL have port LoadByte_Mem  input  2: load width/sign select.
REQ-014 SHALL have port busW  output  32: write data to register file.
REQ-015 SHALL have port Rw_Wr  output  5: write address to register file.
REQ-016 SHALL have ports RegWr_Wr, OverFlow_Wr, Jal_Wr  output  1 each: write controls to register file.
REQ-017 SHALL have port valid_Wr  output  1: WB stage holds a real instruction.
REQ-018 SHALL have port retire_cnt  output  CNT_W: count of retired instructions.

Function
REQ-019 SHALL register all MEM inputs into the MEM/WB register on each clk edge when rst_n=1, stall=0, flush=0: one-cycle latency MEM to WB.
REQ-020 SHALL, when flush=1, load valid=0, RegWr=0, OverFlow=0, Jal=0 and zero data; flush has priority over stall.
REQ-021 SHALL, when stall=1 and flush=0, hold every register bit unchanged.
REQ-022 SHALL drive busW: PC_Addr_Wr+4 (mod 2^32) if Jal_Wr; else the aligned load value if MemToReg_Wr; else ALUResult_Wr.
REQ-023 SHALL align loads from ALUResult_Wr[1:0], little-endian: LoadByte 00 = full word; 01 = signed byte; 10 = unsigned byte; 11 = signed halfword selected by ALUResult_Wr[1] (bit 0 ignored).
REQ-024 SHALL drive Rw_Wr = RA_REG when Jal_Wr=1, else the registered Rw.
REQ-025 SHALL drive RegWr_Wr = valid_Wr & RegWr_reg, forced 0 when Rw_Wr=0.
REQ-026 SHALL pass OverFlow_Wr unmasked; the register file suppresses the write when it is set.
REQ-027 SHALL increment retire_cnt by 1 on each edge where valid_Wr=1 and stall=0, wrapping from all-ones to 0.
REQ-028 SHALL count an instruction with OverFlow_Wr=1 as retired.
REQ-029 SHALL be combinational from MEM/WB register to busW/Rw_Wr/RegWr_Wr, with no extra cycle.

Reset
REQ-030 SHALL, on rst_n=0 at a clk edge, clear all MEM/WB register bits and retire_cnt to 0, overriding stall and flush.
REQ-031 SHALL drive busW=0x00000004? no: busW=ALUResult_Wr=0, Rw_Wr=0, RegWr_Wr=0, OverFlow_Wr=0, Jal_Wr=0, valid_Wr=0 after reset.
REQ-032 SHALL discard any instruction in flight when reset is asserted mid-operation.

Structure
REQ-033 SHALL take LoadByte encodings (LB_WORD, LB_SBYTE, LB_UBYTE, LB_SHALF) and RA index from the shared CPU package.
REQ-034 SHALL contain exactly one sub-module, load_align, combinational, (word, addr[1:0], LoadByte) to aligned 32-bit value.

Verification
REQ-035 Scenario ALU: ALUResult_Mem=0x12345678, Rw=8, RegWr=1, valid=1 -> next cycle busW=0x12345678, Rw_Wr=8, RegWr_Wr=1, retire_cnt +1.
REQ-036 Scenario loads: MemData=0x80FF7F01, addr low bits 01, LoadByte=01 -> busW=0x0000007F; addr 11 -> 0xFFFFFF80; LoadByte=10 addr 11 -> 0x00000080; LoadByte=11 addr 10 -> 0xFFFF80FF.
REQ-037 Scenario Jal: Jal=1, PC=0x00400010, Rw_Mem=0 -> busW=0x00400014, Rw_Wr=31, RegWr_Wr=1, Jal_Wr=1.
REQ-038 Scenario stall/flush: stall 3 cycles then flush with stall=1 -> outputs held 3 cycles, then bubble (valid_Wr=0, RegWr_Wr=0), counter unchanged.
REQ-039 Scenario $zero and overflow: Rw=0, RegWr=1 -> RegWr_Wr=0; OverFlow_Mem=1 -> OverFlow_Wr=1, retire_cnt increments.
REQ-040 Scenario reset/wrap: preload retire_cnt to all-ones, retire one -> 0; assert rst_n=0 while stall=1 -> all outputs 0 next edge.
